// File: rtl/comparator_seq_ctrl_pkg.sv
// Shared constants and types for the byte-serial magnitude comparator.
package comparator_seq_ctrl_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] CASCADE_EQ = 3'b010;

    typedef struct packed {
        logic lt;
        logic et;
        logic gt;
    } cmp_res_t;

endpackage

// File: rtl/comparator_seq_ctrl_if.sv
// Handshake and operand/result bundle between a requester and the comparator.
interface comparator_seq_ctrl_if
    import comparator_seq_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
);
    localparam int W = BYTE_W * NBYTES;

    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         signed_in;
    logic         busy;
    logic         done;
    logic         lt;
    logic         et;
    logic         gt;

    modport master (
        output start, a_in, b_in, signed_in,
        input  busy, done, lt, et, gt
    );

    modport slave (
        input  start, a_in, b_in, signed_in,
        output busy, done, lt, et, gt
    );

endinterface

// File: rtl/comparator_seq_ctrl_comparator8.sv
// 8-bit magnitude comparator; the cascade inputs decide the result when the bytes are equal.
module comparator8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       l,
    input  logic       e,
    input  logic       g,
    output logic       lt,
    output logic       et,
    output logic       gt
);

    always_comb begin
        if (a > b) begin
            {lt, et, gt} = 3'b001;
        end else if (a < b) begin
            {lt, et, gt} = 3'b100;
        end else begin
            {lt, et, gt} = {l, e, g};
        end
    end

endmodule

// File: rtl/comparator_seq_ctrl.sv
// Byte-serial wide comparator: LSB first through one comparator8, result carried in a cascade register.
module comparator_seq_ctrl
    import comparator_seq_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    comparator_seq_ctrl_if.slave  bus
);

    localparam int              W        = BYTE_W * NBYTES;
    localparam int              IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    cmp_res_t         casc_q, casc_d;
    cmp_res_t         res_q, res_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sgn_q, sgn_d;

    logic             raw_lt, raw_et, raw_gt;
    cmp_res_t         byte_res;
    logic             last_byte;

    // The shadow operands shift right each RUN cycle, so the active byte is always at [7:0].
    comparator8 u_cmp8 (
        .a  (a_q[BYTE_W-1:0]),
        .b  (b_q[BYTE_W-1:0]),
        .l  (casc_q.lt),
        .e  (casc_q.et),
        .g  (casc_q.gt),
        .lt (raw_lt),
        .et (raw_et),
        .gt (raw_gt)
    );

    assign last_byte = (idx_q == LAST_IDX);

    always_comb begin
        byte_res = '{lt: raw_lt, et: raw_et, gt: raw_gt};
        if (last_byte && sgn_q && (a_q[BYTE_W-1] != b_q[BYTE_W-1])) begin
            byte_res = a_q[BYTE_W-1] ? cmp_res_t'(3'b100) : cmp_res_t'(3'b001);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        casc_d  = casc_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    sgn_d   = bus.signed_in;
                    idx_d   = '0;
                    casc_d  = cmp_res_t'(CASCADE_EQ);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                casc_d = byte_res;
                a_d    = a_q >> BYTE_W;
                b_d    = b_q >> BYTE_W;
                idx_d  = idx_q + 1'b1;
                if (last_byte) begin
                    res_d   = byte_res;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            casc_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
        end
    end

    // NOTE: the shadow datapath is deliberately not reset; it is always reloaded before it is read.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sgn_q <= sgn_d;
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.lt   = res_q.lt;
    assign bus.et   = res_q.et;
    assign bus.gt   = res_q.gt;

endmodule

// File: doc/comparator_seq_ctrl.md
Name: comparator_seq_ctrl

Overview:
- Sequential multi-byte magnitude comparator built around one shared comparator8 instance (8-bit compare with cascade inputs l/e/g and outputs lt/et/gt).
- Compares two operands of NBYTES bytes each, one byte per cycle, least-significant byte first.
- Feeds each byte's registered result back into the next byte's cascade inputs.
- Provides a start/busy/done handshake and optional two's-complement (signed) comparison. Sits between operand registers and any consumer that needs wide compares without a wide comparator.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand; operand width W = 8*NBYTES; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; accepted only in IDLE.
- a_in  input  W  operand A; sampled on the accepting edge.
- b_in  input  W  operand B; sampled on the accepting edge.
- signed_in  input  1  1 = two's-complement compare; sampled with start.
- busy  output  1  high while a compare is in progress (RUN state).
- done  output  1  one-cycle pulse when the result is updated.
- lt  output  1  A < B; registered, held until the next result.
- et  output  1  A == B; registered, held.
- gt  output  1  A > B; registered, held.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, lt=et=gt=0, byte index=0, cascade register=0. Reset in any state, including mid-RUN, aborts the operation; no done pulse follows.
- IDLE:
  - If start=1 at an edge: latch a_in, b_in and signed_in into shadow registers.
  - Set byte index i=0 and cascade register {l,e,g}={0,1,0}; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle, comparator8 sees byte i of A and B plus the cascade register.
  - At the edge, the cascade register takes comparator8's {lt,et,gt} and i increments.
  - After byte NBYTES-1 is compared, go to DONE.
  - RUN lasts exactly NBYTES cycles.
- Signed override, applied only on the last byte (i = NBYTES-1) with signed_in latched = 1:
  - If A[W-1] != B[W-1]: result is lt when A[W-1]=1, gt when B[W-1]=1; comparator output is ignored.
  - If the sign bits are equal, the comparator output is used unchanged.
- DONE:
  - Lasts one cycle with done=1 and busy=0.
  - lt/et/gt were loaded on the edge entering DONE.
  - Next edge returns to IDLE.
- Latency: start accepted at edge k → busy=1 during cycles k..k+NBYTES-1 → done=1 and result valid in cycle k+NBYTES. Accept-to-accept throughput is NBYTES+2 cycles.
- start in RUN or DONE is ignored; operand changes during RUN have no effect (shadow registers).
- After the first completed compare, exactly one of lt/et/gt is 1. Results persist through IDLE and are overwritten only at the next DONE.
- busy and done are never high in the same cycle.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Cascade seed constant CASCADE_EQ=3'b010 ({l,e,g}).
  - Byte width constant BYTE_W=8.
- Sub-module: the existing comparator8, instantiated once as the shared datapath.
- The controller contains the FSM, byte index counter (clog2(NBYTES) bits), shadow shift/select logic, cascade register, signed override and result register.

Test Plan (NBYTES=4):
- Equal: start with A=B=32'h12345678, unsigned → busy for 4 cycles, done pulse in 5th cycle after accept, {lt,et,gt}=010.
- Cascade across bytes: A=32'h00000100, B=32'h000000FF, unsigned → byte0 gives lt, byte1 overrides to gt; final {lt,et,gt}=001.
- Signed override: A=32'h80000000, B=32'h00000001 → unsigned gives 001 (gt); repeated with signed_in=1 gives 100 (lt). A=32'hFFFFFFFE, B=32'hFFFFFFFF with signed_in=1 gives 100 (lt).
- Busy protection: accept A=5, B=3; then assert start with A=1, B=9 and change a_in/b_in during RUN and DONE → single done pulse, result 001; no second operation starts.
- Reset mid-op: accept A=7, B=7; assert rst on RUN cycle 2 → next cycle busy=0, done=0, {lt,et,gt}=000, no done pulse. A new start then completes normally with 010.
- Back-to-back: start held high continuously with A=2, B=1 → accepts at IDLE edges only; done pulses every 6 cycles (NBYTES+2) with result 001.
